lcd_hex_writer: RTL and testbench
=================================

Name: lcd_hex_writer

Overview:
- Consumes the 32-bit display word from the rotating hex shifter and shows it as 8 ASCII hex characters on line 1 of an HD44780-compatible character LCD, using the 8-bit parallel interface.
- Runs the LCD power-up/init sequence once, then snapshots the input word and writes it out character by character.
- Rewrites the line whenever the input word differs from the last word written.
- Sits between the shifter and the board's LCD pins.

Parameters:
- POWERUP_CYC, 750000: cycles to wait after reset before the first command (15 ms at 50 MHz).
- E_PULSE_CYC, 12: cycles lcd_e is held high per transfer.
- CMD_WAIT_CYC, 2500: cycles to wait after lcd_e falls for a normal command or data byte.
- CLR_WAIT_CYC, 100000: cycles to wait after lcd_e falls for the Clear Display command (0x01).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- data_in  in  32  hex word to display; data_in[31:28] is the leftmost character
- lcd_data  out  8  LCD DB7..DB0
- lcd_rs  out  1  0 = command, 1 = data
- lcd_rw  out  1  always 0 (write only)
- lcd_e  out  1  LCD enable strobe
- busy  out  1  high while init or a frame write is in progress
- frame_done  out  1  one-cycle pulse when the last character's wait completes

Behaviour:
- Reset
  - Clock and reset ports are clk and rst_n: one clock, reset asynchronous and active-low.
  - Reset values: lcd_data=0x00, lcd_rs=0, lcd_rw=0, lcd_e=0, busy=1, frame_done=0, snapshot=0, state=PWR_WAIT, counters=0.
  - Reset asserted mid-transfer forces lcd_e low immediately. Release restarts from PWR_WAIT; no partial frame is resumed.
- Byte transfer (XFER sub-sequence), applied to every command and character:
  - 1 setup cycle: lcd_rs/lcd_data driven, lcd_e=0.
  - E_PULSE_CYC cycles with lcd_e=1.
  - CMD_WAIT_CYC cycles (CLR_WAIT_CYC if the byte is 0x01 with rs=0) with lcd_e=0.
  - lcd_rs/lcd_data stay stable for the whole transfer. Total = 1 + E_PULSE_CYC + wait cycles.
  - lcd_data and lcd_rs hold their last values between transfers.
- States
  - PWR_WAIT: count POWERUP_CYC cycles, then go to INIT.
  - INIT: send the commands 0x38 (8-bit, 2 lines, 5x8), 0x0C (display on, cursor off), 0x06 (increment, no shift), 0x01 (clear), all with rs=0 and in this order. Then go to SET_ADDR.
  - SET_ADDR: in the setup cycle, snapshot <= data_in. Send 0x80 (DDRAM address 0) with rs=0. Go to WRITE.
  - WRITE: char index i = 0..7. Send ASCII of snapshot[31-4i -: 4] with rs=1. After i=7 completes: frame_done=1 for one cycle, go to IDLE.
  - IDLE: busy=0. Each cycle compare data_in with snapshot. If they differ, go to SET_ADDR on the next cycle (busy=1). If equal, stay.
- Hex-to-ASCII mapping:
  - Nibble 0-9 maps to 0x30-0x39.
  - Nibble A-F maps to 0x41-0x46 (uppercase).
- Input sampling and snapshot:
  - data_in may change every cycle. Only the snapshot is displayed.
  - Changes during a frame do not affect that frame. They are detected in IDLE after the frame finishes.
- busy is 1 in PWR_WAIT, INIT, SET_ADDR and WRITE; it is 0 only in IDLE.
- The first frame always follows INIT, regardless of data_in.
- Counters are sized for the largest of the four parameters and must not overflow.

Test Plan:
- All tests use POWERUP_CYC=20, E_PULSE_CYC=2, CMD_WAIT_CYC=5, CLR_WAIT_CYC=10.
- Reset/init: hold rst_n=0 for 3 cycles, then release with data_in=0xFFFF2011.
  - No lcd_e activity for the first 20 cycles.
  - Then 4 command strobes with lcd_data 0x38, 0x0C, 0x06, 0x01 and rs=0.
  - Strobe starts are 8, 8 and 8 cycles apart; the strobe after 0x01 starts 13 cycles after the 0x01 strobe.
- First frame, same run: expect 0x80 (rs=0), then rs=1 bytes 0x46, 0x46, 0x46, 0x46, 0x32, 0x30, 0x31, 0x31.
  - frame_done pulses once.
  - busy falls 1 cycle later.
- Change detection: in IDLE, set data_in=0x91470ABC.
  - Next frame writes 0x80, then 0x39, 0x31, 0x34, 0x37, 0x30, 0x41, 0x42, 0x43.
  - Holding data_in constant afterwards produces no further lcd_e pulses for 500 cycles.
- Mid-frame input change: drive data_in from the rotating shifter, which changes every cycle.
  - Each frame's 8 characters match exactly the word present at its SET_ADDR setup cycle.
  - A new frame begins 1 cycle after each frame_done, because the input has changed.
- Reset mid-transfer: assert rst_n while lcd_e=1 during character 3.
  - lcd_e=0 in the same cycle and all outputs take their reset values.
  - After release, the full init sequence repeats from PWR_WAIT.
- Protocol checker for all tests:
  - lcd_data/lcd_rs never change while lcd_e=1.
  - lcd_rw stays 0 throughout.
  - Every lcd_e high pulse is exactly 2 cycles.

Source files
------------

// File: rtl/lcd_hex_writer_if.sv
// rtl/lcd_hex_writer_if.sv - HD44780 8-bit parallel LCD pin bundle
`timescale 1ns/1ps
interface lcd_hex_writer_if;
  logic [7:0] lcd_data;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;

  modport master (output lcd_data, output lcd_rs, output lcd_rw, output lcd_e);
  modport slave  (input  lcd_data, input  lcd_rs, input  lcd_rw, input  lcd_e);
endinterface

// File: rtl/lcd_hex_writer.sv
// rtl/lcd_hex_writer.sv - shows a 32-bit word as 8 hex chars on HD44780 line 1
`timescale 1ns/1ps
module lcd_hex_writer #(
  parameter int unsigned POWERUP_CYC  = 750000,
  parameter int unsigned E_PULSE_CYC  = 12,
  parameter int unsigned CMD_WAIT_CYC = 2500,
  parameter int unsigned CLR_WAIT_CYC = 100000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      data_in,
  output logic             busy,
  output logic             frame_done,
  lcd_hex_writer_if.master lcd
);

  localparam int unsigned MAX_AB  = (POWERUP_CYC > E_PULSE_CYC) ? POWERUP_CYC : E_PULSE_CYC;
  localparam int unsigned MAX_CD  = (CMD_WAIT_CYC > CLR_WAIT_CYC) ? CMD_WAIT_CYC : CLR_WAIT_CYC;
  localparam int unsigned MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned CW      = $clog2(MAX_CYC + 1);

  // Terminal counts: each phase counts 0 .. N-1.
  localparam logic [CW-1:0] PWR_LAST = CW'(POWERUP_CYC - 1);
  localparam logic [CW-1:0] E_LAST   = CW'(E_PULSE_CYC - 1);
  localparam logic [CW-1:0] CMD_LAST = CW'(CMD_WAIT_CYC - 1);
  localparam logic [CW-1:0] CLR_LAST = CW'(CLR_WAIT_CYC - 1);

  typedef enum logic [2:0] {
    ST_PWR_WAIT,
    ST_INIT,
    ST_SET_ADDR,
    ST_WRITE,
    ST_IDLE
  } state_t;

  // Byte transfer sub-phases shared by INIT, SET_ADDR and WRITE.
  typedef enum logic [1:0] {
    PH_SETUP,
    PH_PULSE,
    PH_WAIT
  } phase_t;

  state_t        state_q;
  phase_t        phase_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q;
  logic [31:0]   snap_q;
  logic [7:0]    lcd_data_q;
  logic          lcd_rs_q;
  logic          lcd_e_q;
  logic          busy_q;
  logic          frame_done_q;
  logic [CW-1:0] wait_last;

  function automatic logic [7:0] init_cmd(input logic [2:0] i);
    case (i)
      3'd0:    return 8'h38;
      3'd1:    return 8'h0C;
      3'd2:    return 8'h06;
      default: return 8'h01;
    endcase
  endfunction

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Character i is the nibble at [31-4i -: 4]; 7-i equals ~i for a 3-bit index.
  function automatic logic [3:0] nib_at(input logic [31:0] w, input logic [2:0] i);
    logic [31:0] s;
    s = w >> {~i, 2'b00};
    return s[3:0];
  endfunction

  // Clear Display needs the long settle time; everything else uses the short one.
  always_comb begin
    wait_last = CMD_LAST;
    if (!lcd_rs_q && (lcd_data_q == 8'h01)) wait_last = CLR_LAST;
  end

  // Main sequencer: power-up wait, init commands, frame writes, change detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_PWR_WAIT;
      phase_q      <= PH_SETUP;
      cnt_q        <= '0;
      idx_q        <= '0;
      snap_q       <= '0;
      lcd_data_q   <= 8'h00;
      lcd_rs_q     <= 1'b0;
      lcd_e_q      <= 1'b0;
      busy_q       <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        ST_PWR_WAIT: begin
          if (cnt_q == PWR_LAST) begin
            cnt_q      <= '0;
            state_q    <= ST_INIT;
            phase_q    <= PH_SETUP;
            idx_q      <= 3'd0;
            lcd_data_q <= init_cmd(3'd0);
            lcd_rs_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        ST_IDLE: begin
          // busy is registered, so it drops the cycle after frame_done
          // unless the word already changed.
          if (data_in != snap_q) begin
            state_q    <= ST_SET_ADDR;
            phase_q    <= PH_SETUP;
            cnt_q      <= '0;
            lcd_data_q <= 8'h80;
            lcd_rs_q   <= 1'b0;
            busy_q     <= 1'b1;
          end else begin
            busy_q <= 1'b0;
          end
        end

        default: begin
          case (phase_q)
            PH_SETUP: begin
              // rs/data were loaded on entry to this cycle; raise the strobe next.
              lcd_e_q <= 1'b1;
              cnt_q   <= '0;
              phase_q <= PH_PULSE;
              if (state_q == ST_SET_ADDR) snap_q <= data_in;
            end

            PH_PULSE: begin
              if (cnt_q == E_LAST) begin
                lcd_e_q <= 1'b0;
                cnt_q   <= '0;
                phase_q <= PH_WAIT;
              end else begin
                cnt_q <= cnt_q + CW'(1);
              end
            end

            default: begin
              if (cnt_q == wait_last) begin
                cnt_q   <= '0;
                phase_q <= PH_SETUP;
                case (state_q)
                  ST_INIT: begin
                    if (idx_q == 3'd3) begin
                      state_q    <= ST_SET_ADDR;
                      lcd_data_q <= 8'h80;
                      lcd_rs_q   <= 1'b0;
                    end else begin
                      idx_q      <= idx_q + 3'd1;
                      lcd_data_q <= init_cmd(idx_q + 3'd1);
                    end
                  end
                  ST_SET_ADDR: begin
                    state_q    <= ST_WRITE;
                    idx_q      <= 3'd0;
                    lcd_data_q <= hex_ascii(nib_at(snap_q, 3'd0));
                    lcd_rs_q   <= 1'b1;
                  end
                  default: begin
                    if (idx_q == 3'd7) begin
                      state_q      <= ST_IDLE;
                      frame_done_q <= 1'b1;
                    end else begin
                      idx_q      <= idx_q + 3'd1;
                      lcd_data_q <= hex_ascii(nib_at(snap_q, idx_q + 3'd1));
                    end
                  end
                endcase
              end else begin
                cnt_q <= cnt_q + CW'(1);
              end
            end
          endcase
        end
      endcase
    end
  end

  assign lcd.lcd_data = lcd_data_q;
  assign lcd.lcd_rs   = lcd_rs_q;
  assign lcd.lcd_rw   = 1'b0;
  assign lcd.lcd_e    = lcd_e_q;
  assign busy         = busy_q;
  assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_lcd_hex_writer.sv
// tb/tb_lcd_hex_writer.sv - scoreboard bench for lcd_hex_writer
`timescale 1ns/1ps
module tb_lcd_hex_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] data_in = 32'h0;
  logic        busy;
  logic        frame_done;

  lcd_hex_writer_if lcd_bus();

  lcd_hex_writer #(
    .POWERUP_CYC (20),
    .E_PULSE_CYC (2),
    .CMD_WAIT_CYC(5),
    .CLR_WAIT_CYC(10)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_in   (data_in),
    .busy      (busy),
    .frame_done(frame_done),
    .lcd       (lcd_bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         checks = 0;
  int         errors = 0;
  int         fd_count = 0;
  logic [8:0] exp_q[$];
  int         strobe_q[$];
  string      hexs = "0123456789ABCDEF";

  task automatic push_frame(input logic [31:0] w);
    logic [31:0] s;
    byte         c;
    exp_q.push_back({1'b0, 8'h80});
    for (int i = 0; i < 8; i++) begin
      s = (w >> (28 - 4 * i)) & 32'hF;
      c = hexs.getc(int'(s));
      exp_q.push_back({1'b1, 8'(c)});
    end
  endtask

  task automatic monitor();
    logic       prev_e = 1'b0;
    logic [8:0] prev_bus = '0;
    logic [8:0] got;
    logic [8:0] want;
    int         hi_len = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_e = 1'b0;
        hi_len = 0;
      end else begin
        checks++;
        if (lcd_bus.lcd_rw !== 1'b0) begin
          errors++;
          $display("FAIL rw_low: got %b want 0 at cyc %0d", lcd_bus.lcd_rw, cyc);
        end
        got = {lcd_bus.lcd_rs, lcd_bus.lcd_data};
        if ((lcd_bus.lcd_e === 1'b1) && !prev_e) begin
          strobe_q.push_back(cyc);
          hi_len = 1;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL strobe_byte: got rs/data %h want no strobe at cyc %0d", got, cyc);
          end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
              errors++;
              $display("FAIL strobe_byte: got rs/data %h want %h at cyc %0d", got, want, cyc);
            end
          end
        end else if ((lcd_bus.lcd_e === 1'b1) && prev_e) begin
          hi_len++;
          checks++;
          if (got !== prev_bus) begin
            errors++;
            $display("FAIL bus_stable: got %h want %h at cyc %0d", got, prev_bus, cyc);
          end
        end else if ((lcd_bus.lcd_e !== 1'b1) && prev_e) begin
          checks++;
          if (hi_len != 2) begin
            errors++;
            $display("FAIL e_width: got %0d want 2 at cyc %0d", hi_len, cyc);
          end
        end
        if (frame_done === 1'b1) fd_count++;
        prev_e   = (lcd_bus.lcd_e === 1'b1);
        prev_bus = got;
      end
    end
  endtask

  task automatic wait_fd(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (lcd_bus.lcd_data !== 8'h00) begin errors++; $display("FAIL rst_data: got %h want 00", lcd_bus.lcd_data); end
    checks++; if (lcd_bus.lcd_rs !== 1'b0) begin errors++; $display("FAIL rst_rs: got %b want 0", lcd_bus.lcd_rs); end
    checks++; if (lcd_bus.lcd_rw !== 1'b0) begin errors++; $display("FAIL rst_rw: got %b want 0", lcd_bus.lcd_rw); end
    checks++; if (lcd_bus.lcd_e !== 1'b0) begin errors++; $display("FAIL rst_e: got %b want 0", lcd_bus.lcd_e); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy: got %b want 1", busy); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_fd: got %b want 0", frame_done); end
  endtask

  task automatic test_init_and_first_frame(input logic [31:0] w);
    int rel;
    int fd0;
    int gap;
    bit ok;
    data_in = w;
    exp_q.delete();
    strobe_q.delete();
    exp_q.push_back({1'b0, 8'h38});
    exp_q.push_back({1'b0, 8'h0C});
    exp_q.push_back({1'b0, 8'h06});
    exp_q.push_back({1'b0, 8'h01});
    push_frame(w);
    fd0 = fd_count;
    @(negedge clk);
    rst_n = 1'b1;
    rel = cyc;
    wait_fd(1000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL init_frame_done: got timeout want pulse"); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_at_done: got %b want 1", busy); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL init_frame_left: got %0d want 0 pending", exp_q.size()); end
    checks++;
    if (strobe_q.size() != 13) begin
      errors++; $display("FAIL init_strobe_count: got %0d want 13", strobe_q.size());
    end else begin
      checks++;
      if (strobe_q[0] - rel != 21) begin
        errors++; $display("FAIL first_strobe: got %0d want 21 cycles after release", strobe_q[0] - rel);
      end
      for (int i = 1; i < 13; i++) begin
        gap = (i == 4) ? 13 : 8;
        checks++;
        if (strobe_q[i] - strobe_q[i-1] != gap) begin
          errors++; $display("FAIL strobe_gap%0d: got %0d want %0d", i, strobe_q[i] - strobe_q[i-1], gap);
        end
      end
    end
    @(negedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_fall: got %b want 0", busy); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL fd_one_cycle: got %b want 0", frame_done); end
    checks++; if (fd_count - fd0 != 1) begin errors++; $display("FAIL fd_pulses: got %0d want 1", fd_count - fd0); end
  endtask

  task automatic test_change();
    int sz;
    int fd0;
    bit ok;
    @(negedge clk);
    strobe_q.delete();
    push_frame(32'h91470ABC);
    data_in = 32'h91470ABC;
    wait_fd(1000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL change_frame_done: got timeout want pulse"); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL change_left: got %0d want 0 pending", exp_q.size()); end
    checks++; if (strobe_q.size() != 9) begin errors++; $display("FAIL change_strobes: got %0d want 9", strobe_q.size()); end
    sz  = strobe_q.size();
    fd0 = fd_count;
    repeat (500) @(negedge clk);
    #1;
    checks++; if (strobe_q.size() != sz) begin errors++; $display("FAIL quiet_strobes: got %0d want 0 new", strobe_q.size() - sz); end
    checks++; if (fd_count != fd0) begin errors++; $display("FAIL quiet_fd: got %0d want 0 new", fd_count - fd0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL quiet_busy: got %b want 0", busy); end
  endtask

  task automatic test_rotate();
    logic [31:0] cur = 32'h12345678;
    int          frames = 0;
    int          guard = 0;
    bit          pend = 1'b1;
    @(negedge clk);
    data_in = cur;
    while (frames < 3 && guard < 1000) begin
      @(negedge clk);
      guard++;
      cur = {cur[30:0], cur[31]};
      data_in = cur;
      if (pend) begin
        push_frame(cur);
        pend = 1'b0;
        checks++;
        if (busy !== 1'b1 || lcd_bus.lcd_data !== 8'h80 || lcd_bus.lcd_e !== 1'b0) begin
          errors++;
          $display("FAIL setup_after_done: got busy %b data %h e %b want 1 80 0", busy, lcd_bus.lcd_data, lcd_bus.lcd_e);
        end
      end
      if (frame_done === 1'b1) begin
        frames++;
        pend = 1'b1;
      end
    end
    checks++; if (frames != 3) begin errors++; $display("FAIL rotate_frames: got %0d want 3", frames); end
    @(negedge clk);
    push_frame(cur);
    checks++;
    if (busy !== 1'b1 || lcd_bus.lcd_data !== 8'h80 || lcd_bus.lcd_e !== 1'b0) begin
      errors++;
      $display("FAIL setup_held: got busy %b data %h e %b want 1 80 0", busy, lcd_bus.lcd_data, lcd_bus.lcd_e);
    end
  endtask

  task automatic test_reset_mid();
    int   n = 0;
    int   guard = 0;
    logic e_last;
    e_last = lcd_bus.lcd_e;
    while (n < 4 && guard < 2000) begin
      @(negedge clk);
      guard++;
      if (lcd_bus.lcd_e === 1'b1 && e_last !== 1'b1 && lcd_bus.lcd_rs === 1'b1) n++;
      e_last = lcd_bus.lcd_e;
    end
    checks++; if (n != 4) begin errors++; $display("FAIL mid_char3: got %0d chars want 4", n); end
    #1 rst_n = 1'b0;
    #1;
    exp_q.delete();
    checks++; if (lcd_bus.lcd_e !== 1'b0) begin errors++; $display("FAIL mid_e: got %b want 0", lcd_bus.lcd_e); end
    checks++; if (lcd_bus.lcd_data !== 8'h00) begin errors++; $display("FAIL mid_data: got %h want 00", lcd_bus.lcd_data); end
    checks++; if (lcd_bus.lcd_rs !== 1'b0) begin errors++; $display("FAIL mid_rs: got %b want 0", lcd_bus.lcd_rs); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b want 1", busy); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL mid_fd: got %b want 0", frame_done); end
    repeat (3) @(negedge clk);
    checks++; if (lcd_bus.lcd_e !== 1'b0) begin errors++; $display("FAIL mid_hold_e: got %b want 0", lcd_bus.lcd_e); end
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_init_and_first_frame(32'hFFFF2011);
    test_change();
    test_rotate();
    test_reset_mid();
    test_init_and_first_frame(32'h00000000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
